// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: buffered UART transmitter for the console path.
// Bytes enter a small FIFO over a valid/ready handshake and are shifted out
// LSB first at CLKS_PER_BIT clocks per bit, back-to-back while data is queued.
//
// Configuration macro: UART_TX_PARITY_EN
//   undefined (default): 8N1 frames, 10 bits.
//   defined: an even-parity bit is inserted between the data bits and the
//            stop bit, 11-bit frames.
//
// Handshake: a byte is accepted at a rising edge where tx_valid && tx_ready;
// tx_ready is decoded from the registered fifo_count only, so it never
// depends on tx_valid, and tx_data must be held while tx_valid && !tx_ready.
//
// state_dbg mirrors the FSM state register (IDLE=0, START=1, DATA=2,
// PARITY=3, STOP=4) so checkers can follow the frame sequencing.
module uart_tx_buffered #(
    parameter int CLKS_PER_BIT = 234,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          uart_tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [2:0]                    state_dbg
);

    localparam int DIV_W = $clog2(CLKS_PER_BIT);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t             state, state_next;
    logic [DIV_W-1:0]   div, div_next;
    logic [2:0]         bit_idx, bit_next;
    logic [7:0]         shreg, shreg_next;
    logic               tx_next;
    logic               push, pop;
    logic               div_last;

    logic [7:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [7:0]         head;

`ifdef UART_TX_PARITY_EN
    logic               parity_bit, parity_next;
`endif

    assign tx_ready  = (fifo_count < CNT_W'(FIFO_DEPTH));
    assign busy      = (state != IDLE) || (fifo_count != '0);
    assign push      = tx_valid && tx_ready;
    assign head      = mem[rd_ptr];
    assign div_last  = (div == DIV_W'(CLKS_PER_BIT - 1));
    assign state_dbg = state;

    // FIFO storage: contents are not reset, only the pointers and count are.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    // FIFO pointers and occupancy; full/empty are told apart by the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // FSM state, bit timing and the registered serial line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            div     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            uart_tx <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            state   <= state_next;
            div     <= div_next;
            bit_idx <= bit_next;
            shreg   <= shreg_next;
            uart_tx <= tx_next;
`ifdef UART_TX_PARITY_EN
            parity_bit <= parity_next;
`endif
        end
    end

    // Next-state logic; a pop loads the head byte and starts a frame, from
    // IDLE or straight out of the last stop-bit cycle for gapless streaming.
    always_comb begin
        state_next = state;
        div_next   = div;
        bit_next   = bit_idx;
        shreg_next = shreg;
        tx_next    = uart_tx;
        pop        = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_next = parity_bit;
`endif
        case (state)
            IDLE: begin
                tx_next = 1'b1;
                if (fifo_count != '0) begin
                    pop        = 1'b1;
                    shreg_next = head;
                    tx_next    = 1'b0;
                    div_next   = '0;
                    state_next = START;
`ifdef UART_TX_PARITY_EN
                    parity_next = ^head;
`endif
                end
            end
            START: begin
                if (div_last) begin
                    div_next   = '0;
                    bit_next   = '0;
                    tx_next    = shreg[0];
                    state_next = DATA;
                end else begin
                    div_next = div + DIV_W'(1);
                end
            end
            DATA: begin
                if (div_last) begin
                    div_next = '0;
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        tx_next    = parity_bit;
                        state_next = PARITY;
`else
                        tx_next    = 1'b1;
                        state_next = STOP;
`endif
                    end else begin
                        bit_next   = bit_idx + 3'd1;
                        shreg_next = {1'b0, shreg[7:1]};
                        tx_next    = shreg[1];
                    end
                end else begin
                    div_next = div + DIV_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (div_last) begin
                    div_next   = '0;
                    tx_next    = 1'b1;
                    state_next = STOP;
                end else begin
                    div_next = div + DIV_W'(1);
                end
            end
`endif
            STOP: begin
                if (div_last) begin
                    div_next = '0;
                    if (fifo_count != '0) begin
                        pop        = 1'b1;
                        shreg_next = head;
                        tx_next    = 1'b0;
                        state_next = START;
`ifdef UART_TX_PARITY_EN
                        parity_next = ^head;
`endif
                    end else begin
                        tx_next    = 1'b1;
                        state_next = IDLE;
                    end
                end else begin
                    div_next = div + DIV_W'(1);
                end
            end
            default: begin
                tx_next    = 1'b1;
                div_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered: directed bench for uart_tx_buffered with
// CLKS_PER_BIT=234 and FIFO_DEPTH=4. Follows UART_TX_PARITY_EN the same way
// as the design: 11-bit frames with even parity when defined, 8N1 otherwise.
module tb_uart_tx_buffered;

    localparam int C     = 234;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB    = 11;
    localparam int F     = 2574;
`else
    localparam int NB    = 10;
    localparam int F     = 2340;
`endif

    logic       clk;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       uart_tx;
    logic       busy;
    logic [2:0] fifo_count;
    logic [2:0] state_dbg;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Scoreboard: bytes accepted by the DUT, in the order they must appear.
    logic [7:0] exp_q[$];

    uart_tx_buffered #(
        .CLKS_PER_BIT(C),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .uart_tx   (uart_tx),
        .busy      (busy),
        .fifo_count(fifo_count),
        .state_dbg (state_dbg)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Hard stop in case something stalls far beyond the planned run length.
    initial begin
        #1000000;
        $display("FAIL timeout got cyc=%0d required finish", cyc);
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) tick();
    endtask

    // Present a byte and hold it until the DUT accepts it; acc is the edge.
    task automatic send_byte(input logic [7:0] b, output int acc);
        logic rdy;
        acc      = -1;
        tx_data  = b;
        tx_valid = 1'b1;
        for (int n = 0; n < 6000; n++) begin
            rdy = tx_ready;
            tick();
            if (rdy) begin
                acc = cyc;
                exp_q.push_back(b);
                break;
            end
        end
        if (acc < 0) check_eq("accept_timeout", 32'd0, 32'd1);
    endtask

    // Check every bit of the frame starting after edge t0 at its first and
    // last cycle, against the next expected byte from the scoreboard.
    task automatic check_frame(input int t0);
        logic [7:0]  b;
        logic [10:0] bits;
        check_eq("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        b = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = b[i];
`ifdef UART_TX_PARITY_EN
        bits[9] = ^b;
`endif
        for (int i = 0; i < NB; i++) begin
            wait_cyc(t0 + i * C);
            check_eq($sformatf("bit%0d_first_%02h", i, b), 32'(uart_tx), 32'(bits[i]));
            wait_cyc(t0 + i * C + C - 1);
            check_eq($sformatf("bit%0d_last_%02h", i, b), 32'(uart_tx), 32'(bits[i]));
        end
    endtask

    // Lone byte into an idle, empty transmitter: latency, frame, busy fall.
    task automatic lone_byte(input logic [7:0] b);
        int acc;
        send_byte(b, acc);
        check_eq("lone_cnt_after_accept", 32'(fifo_count), 32'd1);
        tx_valid = 1'b0;
        tick();
        check_eq("lone_start_low", 32'(uart_tx), 32'd0);
        check_eq("lone_cnt_after_pop", 32'(fifo_count), 32'd0);
        check_frame(acc + 1);
        wait_cyc(acc + F);
        check_eq("lone_busy_before_end", 32'(busy), 32'd1);
        tick();
        check_eq("lone_busy_fall_cycle", 32'(cyc - acc), 32'(1 + F));
        check_eq("lone_busy_low", 32'(busy), 32'd0);
        check_eq("lone_line_idle", 32'(uart_tx), 32'd1);
    endtask

    initial begin : main
        int acc[6];
        int tmp;
        int lows;

        // Reset held with random inputs
        rst_n    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        for (int i = 0; i < 12; i++) begin
            tx_valid = 1'($urandom_range(0, 1));
            tx_data  = 8'($urandom_range(0, 255));
            tick();
            check_eq("rst_uart_tx", 32'(uart_tx), 32'd1);
            check_eq("rst_tx_ready", 32'(tx_ready), 32'd1);
            check_eq("rst_busy", 32'(busy), 32'd0);
            check_eq("rst_fifo_count", 32'(fifo_count), 32'd0);
        end
        tx_valid = 1'b0;
        rst_n    = 1'b1;
        tick();
        tick();
        check_eq("post_rst_uart_tx", 32'(uart_tx), 32'd1);
        check_eq("post_rst_tx_ready", 32'(tx_ready), 32'd1);
        check_eq("post_rst_busy", 32'(busy), 32'd0);
        check_eq("post_rst_fifo_count", 32'(fifo_count), 32'd0);

        // Single byte 0x61: data bits 1,0,0,0,0,1,1,0
        lone_byte(8'h61);
        tick();

        // Streaming 0x00..0x05 with tx_valid held throughout
        send_byte(8'h00, acc[0]);
        fork
            begin
                for (int i = 1; i < 6; i++) begin
                    send_byte(8'(i), tmp);
                    acc[i] = tmp;
                    if (i == 4) begin
                        check_eq("stream_full_cnt", 32'(fifo_count), 32'd4);
                        check_eq("stream_full_ready", 32'(tx_ready), 32'd0);
                    end
                end
                tx_valid = 1'b0;
            end
            begin
                for (int n = 0; n < 6; n++) check_frame(acc[0] + 1 + n * F);
            end
        join
        for (int i = 1; i < 5; i++)
            check_eq($sformatf("stream_acc%0d", i), 32'(acc[i] - acc[0]), 32'(i));
        check_eq("stream_acc5_after_pop", 32'(acc[5] - acc[0]), 32'(F + 2));
        tick();
        tick();
        check_eq("stream_done_busy", 32'(busy), 32'd0);
        check_eq("stream_done_cnt", 32'(fifo_count), 32'd0);

        // Reset during data bit 3 with two bytes queued
        send_byte(8'h00, acc[0]);
        send_byte(8'h55, tmp);
        send_byte(8'hAA, tmp);
        tx_valid = 1'b0;
        wait_cyc(acc[0] + 1 + 4 * C + 100);
        check_eq("midrst_line_before", 32'(uart_tx), 32'd0);
        check_eq("midrst_cnt_before", 32'(fifo_count), 32'd2);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_line_async", 32'(uart_tx), 32'd1);
        check_eq("midrst_cnt_async", 32'(fifo_count), 32'd0);
        check_eq("midrst_busy_async", 32'(busy), 32'd0);
        check_eq("midrst_ready_async", 32'(tx_ready), 32'd1);
        tick();
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        lows = 0;
        for (int i = 0; i < 3 * F; i++) begin
            tick();
            if (uart_tx !== 1'b1) lows++;
        end
        check_eq("midrst_no_residual_low", 32'(lows), 32'd0);
        check_eq("midrst_busy_after", 32'(busy), 32'd0);
        check_eq("midrst_cnt_after", 32'(fifo_count), 32'd0);

        // Parity bytes: 0x07 -> parity 1, 0x03 -> parity 0 when enabled
        lone_byte(8'h07);
        tick();
        lone_byte(8'h03);

        check_eq("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_buffered.md
# uart_tx_buffered

Buffered 8N1 UART transmitter for the CPU-side console path. Accepts bytes over a valid/ready handshake into a small FIFO and serialises them onto `uart_tx` at a fixed baud divider, back-to-back with no idle gap while data is queued. It is the standalone transmit counterpart to the core's UART receive path, letting software stream output without polling per byte.

## Interface
- `CLKS_PER_BIT`, 234, clock cycles per serial bit; must be ≥ 2. Divider counter width is `$clog2(CLKS_PER_BIT)`.
- `FIFO_DEPTH`, 4, FIFO entries; must be a power of two, ≥ 2.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `tx_data` in 8: byte to enqueue.
- `tx_valid` in 1: `tx_data` is valid.
- `tx_ready` out 1: FIFO can accept; equals `fifo_count < FIFO_DEPTH`, decoded from registered count.
- `uart_tx` out 1: serial line, idle high; registered.
- `busy` out 1: high when the FSM is not IDLE or `fifo_count != 0`.
- `fifo_count` out `$clog2(FIFO_DEPTH)+1`: number of queued bytes, excluding the byte being shifted.

## Operation
- Reset values:
  - `uart_tx`=1, `tx_ready`=1, `busy`=0, `fifo_count`=0.
  - FSM=IDLE, divider=0.
  - FIFO pointers cleared; contents discarded.
- Push: `tx_valid && tx_ready` at a rising edge writes `tx_data` at the tail. `tx_data` must be held while `tx_valid && !tx_ready`.
- FSM states: IDLE, START, DATA, PARITY (only with macro), STOP.
  - IDLE: if `fifo_count > 0`, pop the head into the shift register, drive `uart_tx`=0, clear the divider, go to START. Otherwise `uart_tx` stays 1.
  - START, DATA, PARITY, STOP: each bit lasts exactly `CLKS_PER_BIT` cycles, counted by the divider 0..`CLKS_PER_BIT`-1. The state advances when the divider reaches `CLKS_PER_BIT`-1.
  - DATA: 8 bits, LSB first, shift right; bit index 0..7.
  - STOP: `uart_tx`=1 for one bit. On its last cycle:
    - if `fifo_count > 0`, pop and go directly to START, so the start bit follows the stop bit with zero gap;
    - else go to IDLE.
- Simultaneous push and pop: `fifo_count` is unchanged and both pointers advance.
- Full FIFO: `tx_ready`=0 even if a pop occurs the same cycle. No same-cycle refill when full.
- Empty FIFO with a push and the FSM in IDLE: the pop happens on the following edge, never on the same edge as the push.
- Pointer wrap: natural modulo `FIFO_DEPTH`. Full and empty are distinguished by `fifo_count`.
- Reset mid-frame: `uart_tx` goes to 1 asynchronously and the frame is truncated. No residual bits are sent after release.

## Timing
- Accept at edge k into an empty FIFO with the FSM in IDLE:
  - `fifo_count`=1 after k;
  - `uart_tx` falls after edge k+1;
  - `fifo_count` returns to 0 after k+1.
- Frame length: 10·`CLKS_PER_BIT` cycles (11·`CLKS_PER_BIT` with parity).
- `busy` falls on the edge the FSM enters IDLE with an empty FIFO, i.e. exactly 1 + 10·`CLKS_PER_BIT` cycles after a lone accept.
- `tx_ready` reasserts the cycle after the pop that takes `fifo_count` below `FIFO_DEPTH`.

## Configuration
- Macro `UART_TX_PARITY_EN`.
  - Defined: the PARITY state sits between DATA and STOP and drives the even-parity bit, the XOR of the 8 data bits. Frame is 11 bits.
  - Undefined: the PARITY state, its logic and the parity accumulator are absent. DATA goes directly to STOP. Frame is 10 bits (8N1).

## Test plan
- Reset: hold `rst_n`=0 with random inputs. Required: `uart_tx`=1, `tx_ready`=1, `busy`=0, `fifo_count`=0 throughout and after release.
- Single byte 0x61, `CLKS_PER_BIT`=234:
  - start bit low beginning 1 cycle after accept;
  - data bits 1,0,0,0,0,1,1,0, each 234 cycles;
  - stop bit high;
  - `busy` low exactly 2341 cycles after accept.
- Streaming 6 bytes 0x00–0x05 with `tx_valid` held, `FIFO_DEPTH`=4:
  - byte 0 popped immediately, 4 queued;
  - byte 5 stalls with `tx_ready`=0 until the pop at the end of frame 0;
  - 6 contiguous frames with no idle cycles between a stop bit and the next start bit.
- Reset mid-frame: drop `rst_n` during data bit 3 with 2 bytes queued. Required: `uart_tx`=1 immediately, `fifo_count`=0; after release, line stays high with no frames.
- Parity (macro defined):
  - 0x07 yields parity bit 1; 0x03 yields parity bit 0.
  - Each frame lasts 2574 cycles.
  - Macro undefined: the same bytes give 2340-cycle frames with no parity bit.
